sram_like_responder: RTL
========================

// Module: sram_like_responder
// PURPOSE
//  Slave end of the sram-like bus driven by the CPU's inst/data ports: accepts
//  req/addr_ok handshakes, performs the access on a 1-cycle-latency synchronous
//  SRAM, and returns in-order data_ok/rdata after a programmable extra delay.
//  Instantiated once per port in the SoC/testbench wrapper; the delay input is
//  used to stress the CPU's handshake logic.
// PARAMETERS
//  DEPTH    4   max outstanding requests (accepted, data_ok not yet returned); power of 2, >=2
//  RAM_AW   16  SRAM word-address width; ram_addr = addr[RAM_AW+1:2]
// PORTS
//  clk        in   1       clock
//  reset      in   1       synchronous, active-high
//  req        in   1       request valid; held by master until addr_ok
//  wr         in   1       1 = write, 0 = read
//  size       in   2       0 byte / 1 half / 2 word; not checked, wstrb governs writes
//  wstrb      in   4       byte enables for writes
//  addr       in   32      byte address
//  wdata      in   32      write data
//  addr_ok    out  1       request accepted this cycle
//  data_ok    out  1       one-cycle response pulse, one per accepted request, in order
//  rdata      out  32      read data, valid only when data_ok=1 (0 for writes)
//  delay_cfg  in   4       extra response delay, sampled per request at accept
//  ram_en     out  1       SRAM enable
//  ram_wen    out  4       SRAM byte write enables
//  ram_addr   out  RAM_AW  SRAM word address
//  ram_wdata  out  32      SRAM write data
//  ram_rdata  in   32      SRAM read data, valid cycle after ram_en
// BEHAVIOUR
//  - cnt = outstanding count, 0..DEPTH. addr_ok = req && cnt<DEPTH (combinational).
//    Accept = req && addr_ok. At cnt==DEPTH, no accept even if data_ok pops this cycle.
//  - On accept (cycle T): ram_en=1, ram_addr=addr[RAM_AW+1:2], ram_wen=wr?wstrb:0,
//    ram_wdata=wdata (all combinational from inputs); push entry {wr, timer=delay_cfg}.
//    ram_en=0, ram_wen=0 when no accept.
//  - T+1: entry captures ram_rdata (read) or 0 (write); flag data_valid.
//  - Entry timer decrements by 1 each cycle from T+1 while >0 (independent of position).
//  - data_ok/rdata are registered: set for one cycle when head entry has data_valid
//    and timer==0 and was not popped the previous cycle; pop head at that edge.
//    Min latency accept->data_ok = 2 cycles (delay_cfg=0); general 2+delay_cfg,
//    extended further if an older entry is still pending (strict in-order).
//  - Back-to-back: with delay_cfg=0 and req held high, one accept and one data_ok
//    per cycle in steady state (throughput 1/cycle).
//  - Simultaneous accept and pop: cnt unchanged; FIFO pointers wrap modulo DEPTH.
//  - Master cannot stall data_ok; responder never drops or duplicates a response.
//  - Writes followed by read of same address: the read returns new data (SRAM
//    access order = accept order).
//  - Reset: cnt=0, FIFO emptied, pointers 0, data_ok=0, rdata=0; addr_ok follows
//    cnt=0, i.e. addr_ok = req (reset not gating it). In-flight requests at reset are
//    discarded with no data_ok.
// TESTING
//  1 Read, delay_cfg=0, RAM[0x10>>2]=0xDEADBEEF: req@T addr=0x10 -> addr_ok@T,
//    data_ok=1 rdata=0xDEADBEEF @T+2 only.
//  2 Write addr=0x20 wstrb=4'b0011 wdata=0x12345678 over 0xAAAAAAAA, then read 0x20
//    -> write data_ok rdata=0; read returns 0xAAAA5678.
//  3 req held, 6 reads, delay_cfg=0 -> addr_ok every cycle, 6 data_ok pulses on
//    consecutive cycles in address order.
//  4 delay_cfg=15, DEPTH=4, 6 reads -> addr_ok low after 4 accepts until first
//    data_ok (@accept+17); exactly 6 data_ok, in order.
//  5 Read A delay_cfg=8 then read B delay_cfg=0 -> B's data_ok one cycle after A's
//    (no reordering).
//  6 Reset asserted with 3 outstanding -> no data_ok afterwards; next read after
//    reset returns after 2 cycles with correct data.

Source files
------------

// File: rtl/sram_like_responder.sv
// sram_like_responder: slave end of a CPU sram-like bus port.
// Accepts req/addr_ok handshakes, drives a 1-cycle-latency synchronous SRAM,
// and returns in-order data_ok/rdata pulses after a per-request extra delay.
module sram_like_responder #(
  parameter int DEPTH  = 4,
  parameter int RAM_AW = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [1:0]        size_i,
  input  logic [3:0]        wstrb_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              addr_ok_o,
  output logic              data_ok_o,
  output logic [31:0]       rdata_o,
  input  logic [3:0]        delay_cfg_i,
  output logic              ram_en_o,
  output logic [3:0]        ram_wen_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Outstanding-request bookkeeping
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [3:0]       timer_q [DEPTH];
  logic [31:0]      data_q  [DEPTH];

  // Entry pushed last cycle whose SRAM data arrives this cycle
  logic             cap_q;
  logic             cap_wr_q;
  logic [PW-1:0]    cap_idx_q;

  // Registered response
  logic             data_ok_q, data_ok_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             accept_s;
  logic             pop_s;
  logic             head_cap_s;
  logic [31:0]      cap_data_s;
  logic [31:0]      head_data_s;

  // Bits that do not influence behaviour: size is informational only,
  // and the byte offset / high address bits are outside the SRAM window.
  logic unused_s;
  assign unused_s = ^{size_i, addr_i[31:RAM_AW+2], addr_i[1:0]};

  // Accept, pop decision and next-state computation for the response queue
  always_comb begin
    accept_s   = req_i && (cnt_q < FULL);
    head_cap_s = cap_q && (cap_idx_q == rd_ptr_q);
    cap_data_s = cap_wr_q ? 32'h0000_0000 : ram_rdata_i;
    if (valid_q[rd_ptr_q]) begin
      head_data_s = data_q[rd_ptr_q];
    end else begin
      head_data_s = cap_data_s;
    end
    // Head may go as soon as its data is present (stored or arriving now)
    // and its delay has expired; popping advances the head pointer so the
    // same entry can never be reported twice.
    pop_s = (cnt_q != '0) && (valid_q[rd_ptr_q] || head_cap_s) &&
            (timer_q[rd_ptr_q] == 4'd0);
    data_ok_d = pop_s;
    rdata_d   = pop_s ? head_data_s : 32'h0000_0000;

    case ({accept_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    valid_d = valid_q;
    if (cap_q) begin
      valid_d[cap_idx_q] = 1'b1;
    end else begin
      valid_d = valid_d;
    end
    if (pop_s) begin
      valid_d[rd_ptr_q] = 1'b0;
    end else begin
      valid_d = valid_d;
    end
    if (accept_s) begin
      valid_d[wr_ptr_q] = 1'b0;
    end else begin
      valid_d = valid_d;
    end
  end

  // Handshake and SRAM request are combinational from the bus inputs
  assign addr_ok_o   = req_i && (cnt_q < FULL);
  assign ram_en_o    = accept_s;
  assign ram_wen_o   = (accept_s && wr_i) ? wstrb_i : 4'b0000;
  assign ram_addr_o  = addr_i[RAM_AW+1:2];
  assign ram_wdata_o = wdata_i;
  assign data_ok_o   = data_ok_q;
  assign rdata_o     = rdata_q;

  // Queue control state and registered response outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      valid_q   <= '0;
      cap_q     <= 1'b0;
      cap_wr_q  <= 1'b0;
      cap_idx_q <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0000_0000;
    end else begin
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      cap_q     <= accept_s;
      cap_wr_q  <= wr_i;
      cap_idx_q <= wr_ptr_q;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      if (accept_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Per-entry delay timers and captured read data
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        timer_q[i] <= 4'd0;
        data_q[i]  <= 32'h0000_0000;
      end
    end else begin
      // Timers run down independently of queue position
      for (int i = 0; i < DEPTH; i++) begin
        if (timer_q[i] != 4'd0) begin
          timer_q[i] <= timer_q[i] - 4'd1;
        end
      end
      if (cap_q) begin
        data_q[cap_idx_q] <= cap_data_s;
      end
      if (accept_s) begin
        timer_q[wr_ptr_q] <= delay_cfg_i;
      end
    end
  end

endmodule
